// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - drains bytes from the async FIFO read side into UART 8N1 frames
module fifo_uart_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int RD_LATENCY   = 1
) (
    input  logic              clk_d,
    input  logic              rst_n,
    input  logic              en,
    input  logic              read_permission,
    output logic              read_signal,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              tx,
    output logic              busy,
    output logic [15:0]       byte_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]        WAIT_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP} state_t;

    state_t              state, state_next;
    logic [BAUD_W-1:0]   baud_cnt, baud_next;
    logic [2:0]          bit_cnt, bit_next;
    logic [1:0]          wait_cnt, wait_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic                cnt_inc;
    logic                tx_next;
    logic                baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            shift_reg   <= '0;
            tx          <= 1'b1;
            read_signal <= 1'b0;
            busy        <= 1'b0;
            byte_count  <= '0;
        end else begin
            state       <= state_next;
            baud_cnt    <= baud_next;
            bit_cnt     <= bit_next;
            wait_cnt    <= wait_next;
            shift_reg   <= shift_next;
            tx          <= tx_next;
            read_signal <= (state_next == REQ);
            busy        <= (state_next != IDLE);
            if (cnt_inc) begin
                byte_count <= byte_count + 16'd1;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        wait_next  = wait_cnt;
        shift_next = shift_reg;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (en && read_permission) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                wait_next  = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    shift_next = fifo_data;
                    baud_next  = '0;
                    state_next = START;
                end else begin
                    wait_next = wait_cnt + 2'd1;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next  = '0;
                    cnt_inc    = 1'b1;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - directed bench for fifo_uart_drain with a small FIFO read-side model
module tb_fifo_uart_drain;

    localparam int CPB = 4;
    localparam int RDL = 1;

    logic        clk_d = 1'b0;
    logic        rst_n;
    logic        en;
    logic        read_permission;
    logic        read_signal;
    logic [7:0]  fifo_data;
    logic        tx;
    logic        busy;
    logic [15:0] byte_count;

    fifo_uart_drain #(.CLKS_PER_BIT(CPB), .DATA_W(8), .RD_LATENCY(RDL)) dut (
        .clk_d           (clk_d),
        .rst_n           (rst_n),
        .en              (en),
        .read_permission (read_permission),
        .read_signal     (read_signal),
        .fifo_data       (fifo_data),
        .tx              (tx),
        .busy            (busy),
        .byte_count      (byte_count)
    );

    always #5 clk_d = ~clk_d;

    logic [7:0] fifo_q[$];
    logic       rp_gate;
    int         reads;
    int         cyc;
    int         total;
    int         bad;

    always @(posedge clk_d) begin
        cyc <= cyc + 1;
        if (read_signal) begin
            reads <= reads + 1;
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        end
    end

    always @(negedge clk_d) read_permission <= rp_gate && (fifo_q.size() != 0);

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  seq;   // transmitted data bits in order, bit i = i-th bit on the line
        logic [15:0] cnt;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input logic [7:0] seq, input logic [15:0] exp_cnt,
                               input string name, output int req_cyc);
        int  n;
        logic ok;
        logic expb;
        n = 0;
        while (read_signal !== 1'b1 && n < 300) begin
            @(negedge clk_d);
            n++;
        end
        chk({name, " req"}, {31'd0, read_signal}, 32'd1);
        req_cyc = cyc;
        @(negedge clk_d);
        chk({name, " wait"}, {29'd0, read_signal, busy, tx}, 32'b011);
        for (int b = 0; b < 10; b++) begin
            expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : seq[b-1];
            ok = 1'b1;
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk_d);
                if (tx !== expb || busy !== 1'b1 || read_signal !== 1'b0) ok = 1'b0;
            end
            chk($sformatf("%s bit%0d", name, b), {31'd0, ok}, 32'd1);
        end
        @(negedge clk_d);
        chk({name, " idle"}, {30'd0, busy, tx}, 32'b01);
        chk({name, " count"}, {16'd0, byte_count}, {16'd0, exp_cnt});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   req_c, prev_c, r0;
        logic ok;
        vecs[0] = '{8'hA5, 8'b1010_0101, 16'd1};
        vecs[1] = '{8'h00, 8'b0000_0000, 16'd2};
        vecs[2] = '{8'hFF, 8'b1111_1111, 16'd3};
        vecs[3] = '{8'h3C, 8'b0011_1100, 16'd4};
        total = 0; bad = 0; reads = 0; cyc = 0;
        rst_n = 1'b0; en = 1'b1; rp_gate = 1'b1; fifo_data = 8'h00;
        repeat (3) @(negedge clk_d);
        chk("reset", {13'd0, tx, busy, read_signal, byte_count}, {13'd0, 3'b100, 16'd0});
        rst_n = 1'b1;

        // Empty FIFO: no reads, line idle
        ok = 1'b1;
        r0 = reads;
        repeat (100) begin
            @(negedge clk_d);
            if (tx !== 1'b1 || busy !== 1'b0 || read_signal !== 1'b0) ok = 1'b0;
        end
        chk("empty idle", {31'd0, ok}, 32'd1);
        chk("empty reads", reads - r0, 0);
        chk("empty count", {16'd0, byte_count}, 32'd0);

        // Back-to-back frames from the table
        r0 = reads;
        for (int i = 0; i < 4; i++) fifo_q.push_back(vecs[i].data);
        prev_c = 0;
        for (int i = 0; i < 4; i++) begin
            check_frame(vecs[i].seq, vecs[i].cnt, $sformatf("vec%0d", i), req_c);
            if (i > 0) chk($sformatf("period%0d", i), req_c - prev_c, 10 * CPB + RDL + 2);
            prev_c = req_c;
        end
        chk("table reads", reads - r0, 4);

        // en dropped mid-DATA: frame completes, next read held off
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fork
            check_frame(8'h11, 16'd5, "en_drop", req_c);
            begin
                repeat (25) @(negedge clk_d);
                en = 1'b0;
            end
        join
        r0 = reads;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk_d);
            if (read_signal !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("en low hold", {31'd0, ok}, 32'd1);
        chk("en low reads", reads - r0, 0);
        en = 1'b1;
        @(negedge clk_d);
        chk("en resume req", {31'd0, read_signal}, 32'd1);
        check_frame(8'h22, 16'd6, "en_resume", req_c);

        // Reset mid-frame
        fifo_q.push_back(8'h5A);
        r0 = 0;
        while (read_signal !== 1'b1 && r0 < 300) begin
            @(negedge clk_d);
            r0++;
        end
        repeat (2 + CPB + 5 * CPB) @(negedge clk_d);
        chk("pre-reset tx", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid reset", {13'd0, tx, busy, read_signal, byte_count}, {13'd0, 3'b100, 16'd0});
        @(negedge clk_d);
        rst_n = 1'b1;
        fifo_q.push_back(8'h5A);
        check_frame(8'h5A, 16'd1, "after_reset", req_c);

        // byte_count wrap
        force dut.byte_count = 16'hFFFF;
        @(negedge clk_d);
        release dut.byte_count;
        fifo_q.push_back(8'h81);
        check_frame(8'h81, 16'h0000, "wrap", req_c);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
